// File: rtl/regfile_arbiter.sv
// regfile_arbiter: two-requester arbiter/sequencer for the 16x32 register file.
// The ALU-writeback path (req0) and the keypad/display loader (req1) take turns
// issuing single read or write transactions; register-file ports are driven
// from registers so the file sees stable addresses and data for a full cycle.
// Optional build macro: REGARB_FIXED_PRIO_EN (req0 always wins ties).
// Without it, ties are broken round-robin using the last granted requester.
module regfile_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic        req0_we,
    input  logic [3:0]  req0_addr_a,
    input  logic [3:0]  req0_addr_b,
    input  logic [31:0] req0_wdata,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic        req1_we,
    input  logic [3:0]  req1_addr_a,
    input  logic [3:0]  req1_addr_b,
    input  logic [31:0] req1_wdata,
    output logic        req1_ready,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [31:0] rsp_data_a,
    output logic [31:0] rsp_data_b,
    output logic        rf_reg_write,
    output logic [3:0]  rf_dirA,
    output logic [3:0]  rf_dirB,
    output logic [3:0]  rf_dir_WR,
    output logic [31:0] rf_data_in,
    input  logic [31:0] rf_datA,
    input  logic [31:0] rf_datB
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR       = 2'd1,
        RD_ISSUE = 2'd2,
        RD_RSP   = 2'd3
    } state_t;

    state_t      state;
    logic        owner;
`ifndef REGARB_FIXED_PRIO_EN
    logic        last_grant;
`endif

    logic        sel;
    logic        accept;
    logic        sel_we;
    logic [3:0]  sel_addr_a;
    logic [3:0]  sel_addr_b;
    logic [31:0] sel_wdata;

    // Choose which requester would be accepted this cycle, breaking ties by priority policy
    always_comb begin
        sel = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef REGARB_FIXED_PRIO_EN
            sel = 1'b0;
`else
            sel = ~last_grant;
`endif
        end else if (req1_valid) begin
            sel = 1'b1;
        end
    end

    // Combinational readiness in IDLE only, plus the selected request's fields
    always_comb begin
        req0_ready = (state == IDLE) && req0_valid && !sel;
        req1_ready = (state == IDLE) && req1_valid && sel;
        accept     = req0_ready || req1_ready;
        sel_we     = sel ? req1_we     : req0_we;
        sel_addr_a = sel ? req1_addr_a : req0_addr_a;
        sel_addr_b = sel ? req1_addr_b : req0_addr_b;
        sel_wdata  = sel ? req1_wdata  : req0_wdata;
    end

    // Transaction sequencer: captures the accepted request and stages the register-file ports
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            owner        <= 1'b0;
`ifndef REGARB_FIXED_PRIO_EN
            last_grant   <= 1'b1;
`endif
            rf_reg_write <= 1'b0;
            rf_dirA      <= 4'd0;
            rf_dirB      <= 4'd0;
            rf_dir_WR    <= 4'd0;
            rf_data_in   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner      <= sel;
`ifndef REGARB_FIXED_PRIO_EN
                        last_grant <= sel;
`endif
                        rf_dirA    <= sel_addr_a;
                        rf_dirB    <= sel_addr_b;
                        rf_dir_WR  <= sel_addr_a;
                        rf_data_in <= sel_wdata;
                        if (sel_we) begin
                            state        <= WR;
                            rf_reg_write <= 1'b1;
                        end else begin
                            state        <= RD_ISSUE;
                            rf_reg_write <= 1'b0;
                        end
                    end
                end
                WR: begin
                    rf_reg_write <= 1'b0;
                    state        <= IDLE;
                end
                RD_ISSUE: begin
                    state <= RD_RSP;
                end
                RD_RSP: begin
                    state <= IDLE;
                end
                default: begin
                    rf_reg_write <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

    // Completion strobes go to the owner; read data is passed through only while responding
    always_comb begin
        rsp0_valid = ((state == WR) || (state == RD_RSP)) && !owner;
        rsp1_valid = ((state == WR) || (state == RD_RSP)) && owner;
        rsp_data_a = (state == RD_RSP) ? rf_datA : 32'd0;
        rsp_data_b = (state == RD_RSP) ? rf_datB : 32'd0;
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: directed self-checking bench for regfile_arbiter.
// Includes a behavioural 16x32 register file (reads latched on rising edge,
// writes committed on falling edge). Honours REGARB_FIXED_PRIO_EN for grant order.
module tb_regfile_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_we, req0_ready;
    logic [3:0]  req0_addr_a, req0_addr_b;
    logic [31:0] req0_wdata;
    logic        req1_valid, req1_we, req1_ready;
    logic [3:0]  req1_addr_a, req1_addr_b;
    logic [31:0] req1_wdata;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp_data_a, rsp_data_b;
    logic        rf_reg_write;
    logic [3:0]  rf_dirA, rf_dirB, rf_dir_WR;
    logic [31:0] rf_data_in;
    logic [31:0] rf_datA, rf_datB;

    logic [31:0] mem [16];

    int n_compared;
    int n_mismatched;

    regfile_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid   (req0_valid),
        .req0_we      (req0_we),
        .req0_addr_a  (req0_addr_a),
        .req0_addr_b  (req0_addr_b),
        .req0_wdata   (req0_wdata),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_we      (req1_we),
        .req1_addr_a  (req1_addr_a),
        .req1_addr_b  (req1_addr_b),
        .req1_wdata   (req1_wdata),
        .req1_ready   (req1_ready),
        .rsp0_valid   (rsp0_valid),
        .rsp1_valid   (rsp1_valid),
        .rsp_data_a   (rsp_data_a),
        .rsp_data_b   (rsp_data_b),
        .rf_reg_write (rf_reg_write),
        .rf_dirA      (rf_dirA),
        .rf_dirB      (rf_dirB),
        .rf_dir_WR    (rf_dir_WR),
        .rf_data_in   (rf_data_in),
        .rf_datA      (rf_datA),
        .rf_datB      (rf_datB)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file read ports latch their addresses on the rising edge
    always @(posedge clk) begin
        rf_datA <= mem[rf_dirA];
        rf_datB <= mem[rf_dirB];
    end

    // Register-file write port commits on the falling edge
    always @(negedge clk) begin
        if (rf_reg_write) mem[rf_dir_WR] = rf_data_in;
    end

    // Protocol monitor on every falling edge while out of reset
    always @(negedge clk) begin
        logic p0, p1;
        if (!rst_n) begin
            p0 = 1'b0;
            p1 = 1'b0;
        end else begin
            n_compared++;
            if (req0_ready && req1_ready) begin n_mismatched++; $display("[TB] FAIL mon_two_ready: got %b%b required not both", req1_ready, req0_ready); end
            n_compared++;
            if (rsp0_valid && rsp1_valid) begin n_mismatched++; $display("[TB] FAIL mon_two_rsp: got %b%b required not both", rsp1_valid, rsp0_valid); end
            n_compared++;
            if ((req0_ready || req1_ready) && (rsp0_valid || rsp1_valid || rf_reg_write)) begin n_mismatched++; $display("[TB] FAIL mon_ready_outside_idle: ready=%b%b rsp=%b%b we=%b required ready only in IDLE", req1_ready, req0_ready, rsp1_valid, rsp0_valid, rf_reg_write); end
            n_compared++;
            if ((!(rsp0_valid || rsp1_valid) || rf_reg_write) && ((rsp_data_a !== 32'd0) || (rsp_data_b !== 32'd0))) begin n_mismatched++; $display("[TB] FAIL mon_rsp_data_zero: got %h/%h required 0/0", rsp_data_a, rsp_data_b); end
            n_compared++;
            if ((p0 && !req0_valid) || (p1 && !req1_valid)) begin n_mismatched++; $display("[TB] FAIL mon_valid_withdrawn: valid=%b%b required held until ready", req1_valid, req0_valid); end
            p0 = req0_valid && !req0_ready;
            p1 = req1_valid && !req1_ready;
        end
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int idx, input logic we, input logic [3:0] a,
                             input logic [3:0] b, input logic [31:0] wd);
        if (idx == 0) begin
            req0_we = we; req0_addr_a = a; req0_addr_b = b; req0_wdata = wd; req0_valid = 1'b1;
        end else begin
            req1_we = we; req1_addr_a = a; req1_addr_b = b; req1_wdata = wd; req1_valid = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr_a = 4'd0; req0_addr_b = 4'd0; req0_wdata = 32'd0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr_a = 4'd0; req1_addr_b = 4'd0; req1_wdata = 32'd0;
        for (int i = 0; i < 16; i++) mem[i] = 32'hA5A5_0000 | i;
        #3;
        n_compared++; if ({req1_ready, req0_ready} !== 2'b00) begin n_mismatched++; $display("[TB] FAIL reset_ready: got %b required 00", {req1_ready, req0_ready}); end
        n_compared++; if ({rsp1_valid, rsp0_valid} !== 2'b00) begin n_mismatched++; $display("[TB] FAIL reset_rsp: got %b required 00", {rsp1_valid, rsp0_valid}); end
        n_compared++; if (rf_reg_write !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_we: got %b required 0", rf_reg_write); end
        n_compared++; if ({rf_dirA, rf_dirB, rf_dir_WR} !== 12'h000) begin n_mismatched++; $display("[TB] FAIL reset_dirs: got %h required 000", {rf_dirA, rf_dirB, rf_dir_WR}); end
        n_compared++; if (rf_data_in !== 32'd0) begin n_mismatched++; $display("[TB] FAIL reset_data_in: got %h required 0", rf_data_in); end
        n_compared++; if ({rsp_data_a, rsp_data_b} !== 64'd0) begin n_mismatched++; $display("[TB] FAIL reset_rsp_data: got %h required 0", {rsp_data_a, rsp_data_b}); end
        #9;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        drive_req(0, 1'b1, 4'd3, 4'd0, 32'hDEADBEEF);
        #1;
        n_compared++; if ({req1_ready, req0_ready} !== 2'b01) begin n_mismatched++; $display("[TB] FAIL wr_ready: got %b required 01", {req1_ready, req0_ready}); end
        tick();
        req0_valid = 1'b0;
        n_compared++; if (rf_reg_write !== 1'b1) begin n_mismatched++; $display("[TB] FAIL wr_we_high: got %b required 1", rf_reg_write); end
        n_compared++; if ({rsp1_valid, rsp0_valid} !== 2'b01) begin n_mismatched++; $display("[TB] FAIL wr_rsp: got %b required 01", {rsp1_valid, rsp0_valid}); end
        n_compared++; if ({rf_dir_WR, rf_data_in} !== {4'd3, 32'hDEADBEEF}) begin n_mismatched++; $display("[TB] FAIL wr_ports: got %h/%h required 3/deadbeef", rf_dir_WR, rf_data_in); end
        tick();
        n_compared++; if ({rf_reg_write, rsp1_valid, rsp0_valid} !== 3'b000) begin n_mismatched++; $display("[TB] FAIL wr_done: got %b required 000", {rf_reg_write, rsp1_valid, rsp0_valid}); end
        n_compared++; if (mem[3] !== 32'hDEADBEEF) begin n_mismatched++; $display("[TB] FAIL wr_commit: got %h required deadbeef", mem[3]); end
        drive_req(0, 1'b0, 4'd3, 4'd0, 32'd0);
        #1;
        n_compared++; if (req0_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rd_ready: got %b required 1", req0_ready); end
        tick();
        req0_valid = 1'b0;
        n_compared++; if ({rf_dirA, rf_dirB, rsp0_valid, rf_reg_write} !== {4'd3, 4'd0, 1'b0, 1'b0}) begin n_mismatched++; $display("[TB] FAIL rd_issue: got %h%h rsp=%b we=%b required 30 rsp=0 we=0", rf_dirA, rf_dirB, rsp0_valid, rf_reg_write); end
        tick();
        n_compared++; if ({rsp1_valid, rsp0_valid} !== 2'b01) begin n_mismatched++; $display("[TB] FAIL rd_rsp: got %b required 01", {rsp1_valid, rsp0_valid}); end
        n_compared++; if ({rsp_data_a, rsp_data_b} !== {32'hDEADBEEF, 32'hA5A50000}) begin n_mismatched++; $display("[TB] FAIL rd_data: got %h/%h required deadbeef/a5a50000", rsp_data_a, rsp_data_b); end
        tick();
        n_compared++; if ({rsp0_valid, rsp_data_a} !== 33'd0) begin n_mismatched++; $display("[TB] FAIL rd_done: got %b/%h required 0/0", rsp0_valid, rsp_data_a); end
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_grants;
        logic        g_sel;
        logic        a0, a1;
`ifdef REGARB_FIXED_PRIO_EN
        exp_grants = 4'b0000;
`else
        exp_grants = 4'b1010;
`endif
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
        drive_req(0, 1'b0, 4'd1, 4'd2, 32'd0);
        drive_req(1, 1'b0, 4'd4, 4'd6, 32'd0);
        for (int g = 0; g < 4; g++) begin
            g_sel = exp_grants[g];
            #1;
            n_compared++; if ({req1_ready, req0_ready} !== (g_sel ? 2'b10 : 2'b01)) begin n_mismatched++; $display("[TB] FAIL rr_grant%0d: got %b required %b", g, {req1_ready, req0_ready}, (g_sel ? 2'b10 : 2'b01)); end
            tick();
            tick();
            n_compared++; if ({rsp1_valid, rsp0_valid} !== (g_sel ? 2'b10 : 2'b01)) begin n_mismatched++; $display("[TB] FAIL rr_rsp%0d: got %b required %b", g, {rsp1_valid, rsp0_valid}, (g_sel ? 2'b10 : 2'b01)); end
            n_compared++; if ({rsp_data_a, rsp_data_b} !== (g_sel ? {32'hA5A50004, 32'hA5A50006} : {32'hA5A50001, 32'hA5A50002})) begin n_mismatched++; $display("[TB] FAIL rr_data%0d: got %h/%h", g, rsp_data_a, rsp_data_b); end
            tick();
        end
        for (int c = 0; c < 12; c++) begin
            #1;
            a0 = req0_ready;
            a1 = req1_ready;
            tick();
            if (a0) req0_valid = 1'b0;
            if (a1) req1_valid = 1'b0;
        end
        n_compared++; if ({req1_valid, req0_valid} !== 2'b00) begin n_mismatched++; $display("[TB] FAIL rr_drain: got pending %b required 00", {req1_valid, req0_valid}); end
    endtask

    task automatic test_back_to_back();
        drive_req(1, 1'b1, 4'd5, 4'd0, 32'h12345678);
        #1;
        n_compared++; if ({req1_ready, req0_ready} !== 2'b10) begin n_mismatched++; $display("[TB] FAIL b2b_wr_ready: got %b required 10", {req1_ready, req0_ready}); end
        tick();
        req1_valid = 1'b0;
        drive_req(0, 1'b0, 4'd5, 4'd5, 32'd0);
        #1;
        n_compared++; if ({rsp1_valid, rsp0_valid, rf_reg_write, rf_dir_WR} !== {3'b101, 4'd5}) begin n_mismatched++; $display("[TB] FAIL b2b_wr: got rsp=%b%b we=%b wa=%h required 10/1/5", rsp1_valid, rsp0_valid, rf_reg_write, rf_dir_WR); end
        n_compared++; if (req0_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL b2b_busy_ready: got %b required 0", req0_ready); end
        tick();
        n_compared++; if (req0_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL b2b_rd_ready: got %b required 1", req0_ready); end
        tick();
        req0_valid = 1'b0;
        tick();
        n_compared++; if ({rsp1_valid, rsp0_valid} !== 2'b01) begin n_mismatched++; $display("[TB] FAIL b2b_rsp: got %b required 01", {rsp1_valid, rsp0_valid}); end
        n_compared++; if ({rsp_data_a, rsp_data_b} !== {32'h12345678, 32'h12345678}) begin n_mismatched++; $display("[TB] FAIL b2b_raw: got %h/%h required 12345678/12345678", rsp_data_a, rsp_data_b); end
        tick();
    endtask

    task automatic test_reset_during_write();
        drive_req(0, 1'b1, 4'd7, 4'd0, 32'hCAFEF00D);
        #1;
        n_compared++; if (req0_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rstwr_ready: got %b required 1", req0_ready); end
        tick();
        n_compared++; if (rf_reg_write !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rstwr_we_before: got %b required 1", rf_reg_write); end
        #1;
        rst_n = 1'b0;
        req0_valid = 1'b0;
        #1;
        n_compared++; if ({rf_reg_write, rsp1_valid, rsp0_valid, req0_ready} !== 4'b0000) begin n_mismatched++; $display("[TB] FAIL rstwr_async: got we/rsp/ready %b required 0000", {rf_reg_write, rsp1_valid, rsp0_valid, req0_ready}); end
        n_compared++; if (rf_dir_WR !== 4'd0) begin n_mismatched++; $display("[TB] FAIL rstwr_dir: got %h required 0", rf_dir_WR); end
        #4;
        n_compared++; if (mem[7] !== 32'hA5A50007) begin n_mismatched++; $display("[TB] FAIL rstwr_lost: got %h required a5a50007", mem[7]); end
        rst_n = 1'b1;
        tick();
        n_compared++; if ({rf_reg_write, rsp1_valid, rsp0_valid} !== 3'b000) begin n_mismatched++; $display("[TB] FAIL rstwr_after: got %b required 000", {rf_reg_write, rsp1_valid, rsp0_valid}); end
    endtask

    task automatic test_reset_during_read();
        drive_req(1, 1'b0, 4'd1, 4'd2, 32'd0);
        #1;
        n_compared++; if (req1_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rstrd_ready: got %b required 1", req1_ready); end
        tick();
        #1;
        rst_n = 1'b0;
        req1_valid = 1'b0;
        tick();
        n_compared++; if ({rsp1_valid, rsp0_valid} !== 2'b00) begin n_mismatched++; $display("[TB] FAIL rstrd_in_reset: got %b required 00", {rsp1_valid, rsp0_valid}); end
        drive_req(0, 1'b0, 4'd2, 4'd1, 32'd0);
        #2;
        rst_n = 1'b1;
        #1;
        n_compared++; if ({req1_ready, req0_ready} !== 2'b01) begin n_mismatched++; $display("[TB] FAIL rstrd_first_accept: got %b required 01", {req1_ready, req0_ready}); end
        tick();
        req0_valid = 1'b0;
        n_compared++; if ({rsp1_valid, rsp0_valid} !== 2'b00) begin n_mismatched++; $display("[TB] FAIL rstrd_no_stale_rsp: got %b required 00", {rsp1_valid, rsp0_valid}); end
        tick();
        n_compared++; if ({rsp1_valid, rsp0_valid} !== 2'b01) begin n_mismatched++; $display("[TB] FAIL rstrd_new_rsp: got %b required 01", {rsp1_valid, rsp0_valid}); end
        n_compared++; if ({rsp_data_a, rsp_data_b} !== {32'hA5A50002, 32'hA5A50001}) begin n_mismatched++; $display("[TB] FAIL rstrd_data: got %h/%h required a5a50002/a5a50001", rsp_data_a, rsp_data_b); end
        tick();
        n_compared++; if ({rsp1_valid, rsp0_valid} !== 2'b00) begin n_mismatched++; $display("[TB] FAIL rstrd_idle: got %b required 00", {rsp1_valid, rsp0_valid}); end
    endtask

    // Scenario sequence followed by the summary
    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        $display("[TB] regfile_arbiter bench start");
        test_reset();
        test_write_read();
        test_round_robin();
        test_back_to_back();
        test_reset_during_write();
        test_reset_during_read();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Two-requester arbiter and sequencer for the 16-entry x 32-bit register file (two read ports sampled on rising edge, one write port committed on falling edge). Lets the ALU-writeback path and the keypad/display loader share the register file without collisions. Accepts one read or write request at a time and drives the register file's ports with correctly staged timing. Returns read data with a response strobe.

## Interface
- No parameters; widths fixed: data 32, address 4.
- One clock; reset is asynchronous and active-low.
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid / req1_valid  in  1  request pending; must hold, with its fields stable, until accepted.
- req0_we / req1_we  in  1  1 = write, 0 = read.
- req0_addr_a / req1_addr_a  in  4  read address A, or write address when we=1.
- req0_addr_b / req1_addr_b  in  4  read address B; ignored on writes.
- req0_wdata / req1_wdata  in  32  write data.
- req0_ready / req1_ready  out  1  accept; transfer occurs on a rising edge with valid&ready.
- rsp0_valid / rsp1_valid  out  1  one-cycle completion strobe to the owner.
- rsp_data_a / rsp_data_b  out  32  read data, qualified by rspN_valid on a read.
- rf_reg_write  out  1  register-file write enable (registered).
- rf_dirA / rf_dirB / rf_dir_WR  out  4  register-file addresses (registered).
- rf_data_in  out  32  register-file write data (registered).
- rf_datA / rf_datB  in  32  register-file read outputs.

## Operation
- States: IDLE, WR, RD_ISSUE, RD_RSP.
- IDLE: readiness is combinational. req0_ready/req1_ready can be 1 only in IDLE, and only for the selected requester.
  - If one requester is valid, that requester is selected.
  - If both are valid, the requester other than last_grant is selected.
- On accept, the following are captured and last_grant takes the accepted index:
  - owner, we, addresses, wdata.
  - rf_dirA = addr_a; rf_dirB = addr_b; rf_dir_WR = addr_a; rf_data_in = wdata.
- Accept with we=1 -> WR, with rf_reg_write=1. Accept with we=0 -> RD_ISSUE, with rf_reg_write=0.
- WR: the register file commits on this cycle's falling edge. rspN_valid=1 to the owner. Next edge -> IDLE with rf_reg_write=0.
- RD_ISSUE: rf_dirA/rf_dirB are held; the register file samples them at the next rising edge. Next edge -> RD_RSP.
- RD_RSP: rspN_valid=1 to the owner. rsp_data_a = rf_datA and rsp_data_b = rf_datB (combinational pass-through). Next edge -> IDLE.
- Outside RD_RSP, rsp_data_a/b are 0.
- Only one rspN_valid is ever high at a time.
- rf_dir* and rf_data_in hold their last values until the next accept.
- Read-after-write: a write commits before any later read issues; a later read returns the new value.
- A requester that deasserts valid without ready has violated protocol. Behaviour is undefined; the bench flags it.

## Timing
- Reset values: state IDLE, last_grant=1 (so req0 wins the first tie), rf_reg_write=0, rf_dir*=0, rf_data_in=0, rspN_valid=0, rsp_data=0, readys=0.
- Reset does not touch register-file contents.
- Write: accept at edge E0 -> rf_reg_write high E0..E1, commit at the falling edge between. rsp strobe in the same cycle. Back in IDLE after E1.
- Read: accept at E0 -> RD_ISSUE E0..E1 -> register file latches at E1 -> rsp strobe and data valid E1..E2. IDLE after E2.
- Latency from accept: write 1 cycle, read 2 cycles.
- The mandatory IDLE cycle gives a peak throughput of 1 write per 2 cycles, or 1 read per 3 cycles.
- Reset asserted mid-operation:
  - The state machine drops to IDLE immediately and rf_reg_write goes to 0 asynchronously.
  - A write in flight before its falling edge is lost.
  - No response is issued for an aborted request.

## Configuration
- REGARB_FIXED_PRIO_EN defined: req0 always wins ties; last_grant is unused and may be removed.
- REGARB_FIXED_PRIO_EN undefined (default): round-robin tie-break via last_grant, as above.

## Test plan
- Reset, then req0 write addr 3 data 0xDEADBEEF:
  - req0_ready in the first IDLE cycle; rf_reg_write high exactly 1 cycle; rsp0_valid in the same cycle.
  - A following req0 read of A=3, B=0 returns rsp_data_a=0xDEADBEEF 2 cycles after accept.
- Both requesters continuously valid with reads: grants alternate 0,1,0,1 (round-robin); with REGARB_FIXED_PRIO_EN, req0 gets every grant and req1 starves.
- req1 write addr 5 = 0x12345678 immediately followed by req0 read A=5, B=5: both rsp_data equal 0x12345678.
- Reset asserted during WR: rf_reg_write falls without waiting for a clock; state is IDLE; no rsp strobe. The target register keeps its old value if reset precedes the falling edge.
- Reset asserted during RD_ISSUE: no rsp0_valid/rsp1_valid afterwards; the next request is accepted in the first cycle after reset release.
- Protocol check: ready is never high outside IDLE; at most one ready/rsp high per cycle; rsp_data is 0 outside RD_RSP.
